// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a programmed burst from a synchronous FIFO, with
// at most one read in flight, and presents each word on a valid/ready port.
// Keeps a running sum and count of the words delivered downstream, and a
// sticky error flag for read-on-empty.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [CNT_WIDTH-1:0]            burst_len,
  input  logic                            fifo_empty,
  input  logic [DATA_WIDTH-1:0]           fifo_d_out,
  input  logic                            fifo_rd_ack,
  input  logic                            fifo_rd_err,
  output logic                            fifo_rd_en,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [CNT_WIDTH-1:0]            rd_count,
  output logic [DATA_WIDTH+CNT_WIDTH-1:0] sum
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] remaining;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state; rd_en and done decode straight from state so a pop never
  // lags the empty flag and done lasts exactly the DONE cycle.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (burst_len == '0) ? DONE : REQ;
      REQ: begin
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) state_nxt = WAIT;
      end
      WAIT: begin
        // A read error does not consume a word: go back and retry.
        if (fifo_rd_ack)      state_nxt = OUT;
        else if (fifo_rd_err) state_nxt = REQ;
      end
      OUT: if (m_ready) state_nxt = (remaining == CNT_WIDTH'(1)) ? DONE : REQ;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping, output word register and statistics
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      rd_count  <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          remaining <= burst_len;
          sum       <= '0;
          rd_count  <= '0;
          err       <= 1'b0;
          busy      <= 1'b1;
        end
        WAIT: begin
          if (fifo_rd_ack) begin
            m_data  <= fifo_d_out;
            m_valid <= 1'b1;
          end else if (fifo_rd_err) begin
            err <= 1'b1;
          end
        end
        OUT: if (m_ready) begin
          m_valid   <= 1'b0;
          sum       <= sum + {{CNT_WIDTH{1'b0}}, m_data};
          rd_count  <= rd_count + 1'b1;
          remaining <= remaining - 1'b1;
        end
        DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small behavioural FIFO that
// can be told to answer one chosen read with rd_err.
module tb_fifo_burst_reader;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          fifo_empty;
  logic [DW-1:0] fifo_d_out;
  logic          fifo_rd_ack;
  logic          fifo_rd_err;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] rd_count;
  logic [DW+CW-1:0] sum;

  int checks   = 0;
  int failures = 0;

  fifo_burst_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .burst_len(burst_len),
    .fifo_empty(fifo_empty), .fifo_d_out(fifo_d_out), .fifo_rd_ack(fifo_rd_ack),
    .fifo_rd_err(fifo_rd_err), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done), .err(err),
    .rd_count(rd_count), .sum(sum)
  );

  always #5 clk = ~clk;

  // FIFO model: wr_ptr owned by the stimulus, rd_ptr by the model.
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int nreads = 0;
  int inj_at = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  // Read side: answer each sampled rd_en with ack+data or err next cycle
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_rd_ack <= 1'b0;
      fifo_rd_err <= 1'b0;
      fifo_d_out  <= '0;
    end else begin
      fifo_rd_ack <= 1'b0;
      fifo_rd_err <= 1'b0;
      if (fifo_rd_en) begin
        nreads <= nreads + 1;
        if (nreads + 1 == inj_at || wr_ptr == rd_ptr) begin
          fifo_rd_err <= 1'b1;
        end else begin
          fifo_d_out  <= mem[rd_ptr[5:0]];
          rd_ptr      <= rd_ptr + 1;
          fifo_rd_ack <= 1'b1;
        end
      end
    end
  end

  // Monitors: count rd_en cycles and record delivered words
  int          rden_cnt = 0;
  logic [DW-1:0] dlv [0:255];
  int          dlv_n = 0;
  always @(posedge clk) begin
    if (reset_n && fifo_rd_en) rden_cnt <= rden_cnt + 1;
    if (reset_n && m_valid && m_ready) begin
      dlv[dlv_n[7:0]] <= m_data;
      dlv_n <= dlv_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_start(input logic [CW-1:0] len);
    @(negedge clk);
    start = 1'b1;
    burst_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // sel: 0 = done, 1 = m_valid, 2 = rd_count==1; checked on negedges
  task automatic wait_for(input int sel, input int max, input string tag);
    bit hit = 0;
    for (int i = 0; i < max; i++) begin
      if ((sel == 0 && done) || (sel == 1 && m_valid) || (sel == 2 && rd_count == 1)) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, 64'(hit), 64'd1);
  endtask

  int rb, db;

  initial begin
    reset_n = 1'b0; start = 1'b0; burst_len = '0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_busy",    64'(busy), 0);
    chk("rst_done",    64'(done), 0);
    chk("rst_err",     64'(err), 0);
    chk("rst_rd_en",   64'(fifo_rd_en), 0);
    chk("rst_count",   64'(rd_count), 0);
    chk("rst_sum",     64'(sum), 0);
    chk("rst_m_data",  64'(m_data), 0);
    reset_n = 1'b1;

    // 1: basic 3-word burst, no backpressure
    push(32'h11); push(32'h22); push(32'h33);
    rb = rden_cnt; db = dlv_n;
    pulse_start(4'd3);
    chk("t1_busy", 64'(busy), 1);
    wait_for(0, 40, "t1_done_seen");
    chk("t1_sum",   64'(sum), 64'h66);
    chk("t1_count", 64'(rd_count), 3);
    chk("t1_err",   64'(err), 0);
    chk("t1_rden",  64'(rden_cnt - rb), 3);
    chk("t1_w0", 64'(dlv[db]),     64'h11);
    chk("t1_w1", 64'(dlv[db + 1]), 64'h22);
    chk("t1_w2", 64'(dlv[db + 2]), 64'h33);
    @(negedge clk);
    chk("t1_done_1cyc", 64'(done), 0);
    chk("t1_busy_off",  64'(busy), 0);

    // 2: start on empty FIFO stalls in REQ until data arrives
    rb = rden_cnt;
    pulse_start(4'd2);
    repeat (5) @(negedge clk);
    chk("t2_stall_rden", 64'(rden_cnt - rb), 0);
    chk("t2_stall_busy", 64'(busy), 1);
    push(32'hAA); push(32'hBB);
    wait_for(0, 40, "t2_done_seen");
    chk("t2_sum",   64'(sum), 64'h165);
    chk("t2_count", 64'(rd_count), 2);

    // 3: backpressure on first word holds the output and blocks reads
    m_ready = 1'b0;
    push(32'h44); push(32'h55);
    pulse_start(4'd2);
    wait_for(1, 20, "t3_valid_seen");
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 64'(m_valid), 1);
      chk("t3_hold_data",  64'(m_data), 64'h44);
      chk("t3_hold_rden",  64'(fifo_rd_en), 0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    wait_for(0, 40, "t3_done_seen");
    chk("t3_sum",   64'(sum), 64'h99);
    chk("t3_count", 64'(rd_count), 2);

    // 4: one read error on the second read; retried, err sticky
    inj_at = nreads + 2;
    push(32'h1); push(32'h2); push(32'h3);
    rb = rden_cnt;
    pulse_start(4'd3);
    wait_for(0, 60, "t4_done_seen");
    chk("t4_err",   64'(err), 1);
    chk("t4_count", 64'(rd_count), 3);
    chk("t4_sum",   64'(sum), 64'h6);
    chk("t4_rden",  64'(rden_cnt - rb), 4);
    @(negedge clk);
    chk("t4_err_sticky", 64'(err), 1);
    inj_at = 0;

    // 5: burst_len=0 -> done one cycle later, err cleared, no reads
    rb = rden_cnt;
    pulse_start(4'd0);
    chk("t5_done",  64'(done), 1);
    chk("t5_busy",  64'(busy), 1);
    chk("t5_err_clr", 64'(err), 0);
    chk("t5_sum",   64'(sum), 0);
    chk("t5_count", 64'(rd_count), 0);
    @(negedge clk);
    chk("t5_done_off", 64'(done), 0);
    chk("t5_busy_off", 64'(busy), 0);
    chk("t5_rden", 64'(rden_cnt - rb), 0);

    // 5b: start while busy is ignored
    push(32'h7); push(32'h8);
    pulse_start(4'd2);
    start = 1'b1; burst_len = 4'd5;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, 40, "t5b_done_seen");
    chk("t5b_count", 64'(rd_count), 2);
    chk("t5b_sum",   64'(sum), 64'hF);

    // 6: async reset mid-burst while holding a word in OUT
    push(32'h9); push(32'hA);
    pulse_start(4'd2);
    wait_for(2, 40, "t6_first_word");
    m_ready = 1'b0;
    wait_for(1, 20, "t6_valid_seen");
    #2 reset_n = 1'b0;
    #1;
    chk("t6_m_valid", 64'(m_valid), 0);
    chk("t6_busy",    64'(busy), 0);
    chk("t6_rd_en",   64'(fifo_rd_en), 0);
    chk("t6_sum",     64'(sum), 0);
    chk("t6_count",   64'(rd_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_resume", 64'(busy), 0);
    push(32'h5); push(32'h6);
    pulse_start(4'd2);
    wait_for(0, 40, "t6_done_seen");
    chk("t6_new_sum",   64'(sum), 64'hB);
    chk("t6_new_count", 64'(rd_count), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
